// File: rtl/pll_reset_sequencer.sv
// Staggered reset sequencer for the 10 MHz PLL domain: waits for stable lock,
// releases core then peripheral resets, then signals ready and emits a periodic tick.
module pll_reset_sequencer #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1000,
  parameter int unsigned STAGGER_CYCLES     = 16,
  parameter int unsigned TICK_DIV           = 10000000,
  parameter int unsigned LOSS_CNT_W         = 8
) (
  input  logic                  CLK_10MHz,
  input  logic                  reset,
  input  logic                  locked,
  input  logic                  sw_reset_req,
  output logic                  rst_core,
  output logic                  rst_periph,
  output logic                  sys_ready,
  output logic                  tick,
  output logic [1:0]            state_out,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int unsigned SEQ_MAX = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ?
                                    LOCK_STABLE_CYCLES : STAGGER_CYCLES;
  localparam int unsigned SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;
  localparam int unsigned DIV_W   = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABILIZE = 2'd1,
    S_STAGGER   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_lock_meta;
  logic                  r_lock_s;
  logic [SEQ_W-1:0]      r_seq_cnt;
  logic [DIV_W-1:0]      r_div_cnt;
  logic                  r_rst_core;
  logic                  r_rst_periph;
  logic                  r_sys_ready;
  logic                  r_tick;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;

  logic w_lock_lost;
  logic w_stab_done;
  logic w_stag_done;
  logic w_div_wrap;

  // Lock loss only counts once the core has been let out of reset
  assign w_lock_lost = ((r_state == S_STAGGER) || (r_state == S_RUN)) && !r_lock_s;
  assign w_stab_done = (r_seq_cnt == SEQ_W'(LOCK_STABLE_CYCLES - 1));
  assign w_stag_done = (r_seq_cnt == SEQ_W'(STAGGER_CYCLES - 1));
  assign w_div_wrap  = (r_div_cnt == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge CLK_10MHz or posedge reset) begin
    if (reset) begin
      r_lock_meta  <= 1'b0;
      r_lock_s     <= 1'b0;
      r_state      <= S_WAIT_LOCK;
      r_seq_cnt    <= '0;
      r_div_cnt    <= '0;
      r_rst_core   <= 1'b1;
      r_rst_periph <= 1'b1;
      r_sys_ready  <= 1'b0;
      r_tick       <= 1'b0;
      r_loss_cnt   <= '0;
    end else begin
      r_lock_meta <= locked;
      r_lock_s    <= r_lock_meta;
      r_tick      <= 1'b0;

      if (w_lock_lost || sw_reset_req) begin
        // Abort: resets reassert on this same edge, sequence restarts from scratch
        r_state      <= S_WAIT_LOCK;
        r_seq_cnt    <= '0;
        r_div_cnt    <= '0;
        r_rst_core   <= 1'b1;
        r_rst_periph <= 1'b1;
        r_sys_ready  <= 1'b0;
        if (w_lock_lost && (r_loss_cnt != '1)) begin
          r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
        end
      end else begin
        case (r_state)
          S_WAIT_LOCK: begin
            r_seq_cnt <= '0;
            if (r_lock_s) begin
              r_state <= S_STABILIZE;
            end
          end
          S_STABILIZE: begin
            if (!r_lock_s) begin
              r_state   <= S_WAIT_LOCK;
              r_seq_cnt <= '0;
            end else if (w_stab_done) begin
              r_state    <= S_STAGGER;
              r_seq_cnt  <= '0;
              r_rst_core <= 1'b0;
            end else begin
              r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
            end
          end
          S_STAGGER: begin
            if (w_stag_done) begin
              r_state      <= S_RUN;
              r_seq_cnt    <= '0;
              r_div_cnt    <= '0;
              r_rst_periph <= 1'b0;
              r_sys_ready  <= 1'b1;
            end else begin
              r_seq_cnt <= r_seq_cnt + SEQ_W'(1);
            end
          end
          S_RUN: begin
            if (w_div_wrap) begin
              r_div_cnt <= '0;
              r_tick    <= 1'b1;
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign rst_core        = r_rst_core;
  assign rst_periph      = r_rst_periph;
  assign sys_ready       = r_sys_ready;
  assign tick            = r_tick;
  assign state_out       = r_state;
  assign lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: a sequence-age reference model
// predicts every cycle's outputs; a negedge monitor pops and compares.
module tb_pll_reset_sequencer;

  localparam int unsigned LSC  = 8;
  localparam int unsigned STG  = 4;
  localparam int unsigned TD   = 5;
  localparam int unsigned LW   = 2;
  localparam int          LMAX = 3;

  typedef struct packed {
    logic [1:0]    st;
    logic          rc;
    logic          rp;
    logic          rdy;
    logic          tk;
    logic [LW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          locked;
  logic          sw_reset_req;
  logic          rst_core;
  logic          rst_periph;
  logic          sys_ready;
  logic          tick;
  logic [1:0]    state_out;
  logic [LW-1:0] lock_loss_count;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES (LSC),
    .STAGGER_CYCLES     (STG),
    .TICK_DIV           (TD),
    .LOSS_CNT_W         (LW)
  ) dut (
    .CLK_10MHz       (clk),
    .reset           (reset),
    .locked          (locked),
    .sw_reset_req    (sw_reset_req),
    .rst_core        (rst_core),
    .rst_periph      (rst_periph),
    .sys_ready       (sys_ready),
    .tick            (tick),
    .state_out       (state_out),
    .lock_loss_count (lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Model: age = edges since STABILIZE entry, -1 while waiting for lock
  int   m_age  = -1;
  int   m_loss = 0;
  logic m_s1   = 1'b0;
  logic m_s2   = 1'b0;

  function automatic exp_t model_out();
    exp_t e;
    e.cnt = LW'(m_loss);
    if (m_age < 0)                     e.st = 2'd0;
    else if (m_age < int'(LSC))        e.st = 2'd1;
    else if (m_age < int'(LSC + STG))  e.st = 2'd2;
    else                               e.st = 2'd3;
    e.rc  = (m_age < int'(LSC));
    e.rp  = (m_age < int'(LSC + STG));
    e.rdy = (m_age >= int'(LSC + STG));
    e.tk  = (m_age >= int'(LSC + STG + TD)) && (((m_age - int'(LSC + STG)) % int'(TD)) == 0);
    return e;
  endfunction

  task automatic model_edge(input logic r, input logic lk, input logic sw);
    logic ls;
    if (r) begin
      m_age = -1; m_loss = 0; m_s1 = 1'b0; m_s2 = 1'b0;
    end else begin
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = lk;
      if (m_age >= int'(LSC) && !ls) begin
        if (m_loss < LMAX) m_loss++;
        m_age = -1;
      end else if (sw) begin
        m_age = -1;
      end else if (m_age < 0) begin
        if (ls) m_age = 0;
      end else if (m_age < int'(LSC) && !ls) begin
        m_age = -1;
      end else begin
        m_age++;
      end
    end
  endtask

  // Drive one cycle of inputs, predict the post-edge outputs, advance to next negedge
  task automatic step(input logic r, input logic lk, input logic sw);
    reset        = r;
    locked       = lk;
    sw_reset_req = sw;
    model_edge(r, lk, sw);
    exp_q.push_back(model_out());
    @(negedge clk);
    #1;
  endtask

  task automatic run_n(input int n, input logic lk);
    for (int i = 0; i < n; i++) step(1'b0, lk, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{state_out, rst_core, rst_periph, sys_ready, tick, lock_loss_count};
      n_vec++;
      if (g !== e) begin
        n_miss++;
        $display("FAIL cycle t=%0t st/rc/rp/rdy/tk/cnt got %0d/%b/%b/%b/%b/%0d expected %0d/%b/%b/%b/%b/%0d",
                 $time, g.st, g.rc, g.rp, g.rdy, g.tk, g.cnt, e.st, e.rc, e.rp, e.rdy, e.tk, e.cnt);
      end
    end
  end

  task automatic check_now(input string name, input exp_t e);
    exp_t g;
    g = '{state_out, rst_core, rst_periph, sys_ready, tick, lock_loss_count};
    n_vec++;
    if (g !== e) begin
      n_miss++;
      $display("FAIL %s got %0d/%b/%b/%b/%b/%0d expected %0d/%b/%b/%b/%b/%0d", name,
               g.st, g.rc, g.rp, g.rdy, g.tk, g.cnt, e.st, e.rc, e.rp, e.rdy, e.tk, e.cnt);
    end
  endtask

  initial begin
    logic lk_r;
    logic [LW-1:0] sat_exp;
    exp_t rst_exp;
    reset = 1'b1; locked = 1'b0; sw_reset_req = 1'b0;
    rst_exp = '{2'd0, 1'b1, 1'b1, 1'b0, 1'b0, LW'(0)};
    @(negedge clk); #1;

    // Power-up: reset held, then no lock
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    run_n(20, 1'b0);
    // Clean lock through several ticks
    run_n(35, 1'b1);
    // Lock loss in RUN, then relock
    run_n(4, 1'b0);
    run_n(30, 1'b1);
    // Lone sw_reset_req in RUN, then glitch during STABILIZE
    step(1'b0, 1'b1, 1'b1);
    run_n(4, 1'b1);
    run_n(3, 1'b0);
    run_n(30, 1'b1);
    // sw_reset_req coinciding with synchronized lock loss
    run_n(2, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    run_n(1, 1'b0);
    run_n(30, 1'b1);
    // Three more losses drive the 2-bit counter into saturation
    for (int k = 0; k < 3; k++) begin
      run_n(4, 1'b0);
      run_n(20, 1'b1);
    end
    sat_exp = '1;
    n_vec++;
    if (lock_loss_count !== sat_exp) begin
      n_miss++;
      $display("FAIL saturation got %0d expected %0d", lock_loss_count, sat_exp);
    end
    // Restart and async reset mid-STAGGER
    run_n(4, 1'b0);
    for (int i = 0; i < 40 && model_out().st != 2'd2; i++) step(1'b0, 1'b1, 1'b0);
    run_n(1, 1'b1);
    reset = 1'b1;
    #1;
    check_now("async_reset", rst_exp);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0);
    run_n(20, 1'b1);

    // Randomized lock behaviour with occasional software and hard resets
    lk_r = 1'b1;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 19) == 0) lk_r = ~lk_r;
      step(($urandom_range(0, 299) == 0), lk_r,
           ($urandom_range(0, 59) == 0));
    end

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
